blackjack_hand_scorer: RTL

BLACKJACK_HAND_SCORER -- requirements
Module: blackjack_hand_scorer

---
 rtl/blackjack_hand_scorer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/blackjack_hand_scorer.sv
// Blackjack hand scorer: fetches cards from an upstream source and tracks the best hand value and status flags.
// Define DEALER_AUTO_EN to have the hand draw automatically until the score reaches STAND_AT.
module blackjack_hand_scorer #(
    parameter int CARD_LAT = 1,
    parameter int STAND_AT = 17
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       deal_start_i,
    input  logic       hit_i,
    input  logic       stand_i,
    input  logic [7:0] card_i,
    output logic       request_card_o,
    output logic [5:0] score_o,
    output logic [3:0] card_count_o,
    output logic       soft_o,
    output logic       bust_o,
    output logic       blackjack_o,
    output logic       done_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        ADD  = 3'd3,
        PLAY = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic [2:0] LAT = 3'(CARD_LAT);

    if (CARD_LAT < 1 || CARD_LAT > 7 || STAND_AT < 0 || STAND_AT > 63) begin : g_param_check
        $error("blackjack_hand_scorer: CARD_LAT or STAND_AT out of range");
    end

    state_t     state, state_n;
    logic [2:0] lat_cnt;
    logic [3:0] rank_q;
    logic [5:0] hard_q;
    logic       ace_q;

    logic [5:0] hard_n;
    logic       ace_n;
    logic [3:0] count_n;
    logic [5:0] score_n;
    logic       soft_n;
    logic       last_wait;
    logic       card_ok;
    logic       card_unused;

    assign card_unused = ^card_i[7:4];

    function automatic logic rank_valid(input logic [3:0] r);
        return (r >= 4'd1) && (r <= 4'd13);
    endfunction

    function automatic logic [3:0] rank_value(input logic [3:0] r);
        if (r >= 4'd11 && r <= 4'd13) return 4'd10;
        if (r >= 4'd1 && r <= 4'd10)  return r;
        return 4'd0;
    endfunction

    assign last_wait = (lat_cnt == LAT);
    assign card_ok   = rank_valid(card_i[3:0]);

    // Hand totals as they will stand once the latched card is added.
    always_comb begin
        hard_n  = hard_q + {2'b00, rank_value(rank_q)};
        ace_n   = ace_q | (rank_q == 4'd1);
        count_n = (card_count_o == 4'd15) ? 4'd15 : card_count_o + 4'd1;
        score_n = hard_n;
        soft_n  = 1'b0;
        if (ace_n && hard_n <= 6'd11) begin
            score_n = hard_n + 6'd10;
            soft_n  = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (deal_start_i) begin
            state_n = REQ;
        end else begin
            case (state)
                IDLE: state_n = IDLE;
                REQ:  state_n = WAIT;
                WAIT: if (last_wait) state_n = card_ok ? ADD : REQ;
                ADD: begin
                    if (score_n > 6'd21)                          state_n = DONE;
                    else if (count_n == 4'd2 && score_n == 6'd21) state_n = DONE;
                    else if (count_n < 4'd2)                      state_n = REQ;
                    else                                          state_n = PLAY;
                end
                PLAY: begin
`ifdef DEALER_AUTO_EN
                    // Dealer stands on any 17, soft or hard.
                    if (score_o < 6'(STAND_AT)) state_n = REQ;
                    else                        state_n = DONE;
`else
                    if (stand_i)    state_n = DONE;
                    else if (hit_i) state_n = REQ;
`endif
                end
                DONE:    state_n = DONE;
                default: state_n = IDLE;
            endcase
        end
    end

`ifdef DEALER_AUTO_EN
    logic ctrl_unused;
    assign ctrl_unused = hit_i ^ stand_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            request_card_o <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            lat_cnt        <= 3'd0;
            rank_q         <= 4'd0;
            hard_q         <= 6'd0;
            ace_q          <= 1'b0;
            card_count_o   <= 4'd0;
            score_o        <= 6'd0;
            soft_o         <= 1'b0;
            bust_o         <= 1'b0;
            blackjack_o    <= 1'b0;
        end else begin
            request_card_o <= (state_n == REQ);
            busy_o         <= (state_n == REQ) || (state_n == WAIT) || (state_n == ADD);
            done_o         <= (state_n == DONE);
            if (deal_start_i) begin
                // A card still in flight is dropped simply by leaving WAIT/ADD.
                lat_cnt      <= 3'd0;
                rank_q       <= 4'd0;
                hard_q       <= 6'd0;
                ace_q        <= 1'b0;
                card_count_o <= 4'd0;
                score_o      <= 6'd0;
                soft_o       <= 1'b0;
                bust_o       <= 1'b0;
                blackjack_o  <= 1'b0;
            end else begin
                case (state)
                    REQ: lat_cnt <= 3'd1;
                    WAIT: begin
                        lat_cnt <= lat_cnt + 3'd1;
                        if (last_wait) rank_q <= card_i[3:0];
                    end
                    ADD: begin
                        hard_q       <= hard_n;
                        ace_q        <= ace_n;
                        card_count_o <= count_n;
                        score_o      <= score_n;
                        soft_o       <= soft_n;
                        bust_o       <= (score_n > 6'd21);
                        blackjack_o  <= (count_n == 4'd2) && (score_n == 6'd21);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
